facelet_sampler: RTL

//  Reads back cube-start detection (CubeX_Start/CubeY_Start/CubeDetected) and samples the 3x3 facelet grid.

---
 rtl/facelet_pkg.sv | 22 ++
 rtl/facelet_grid_ctr.sv | 57 +++++
 rtl/facelet_sampler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/facelet_pkg.sv
// rtl/facelet_pkg.sv - shared types and constants for the facelet sampler
package facelet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    SAMPLE,
    OUT
  } sampler_state_t;

  localparam int NUM_FACELETS = 9;
  localparam int GRID_DIM     = 3;

  typedef logic [3:0] facelet_idx_t;

  // Row-major facelet index from grid position.
  function automatic facelet_idx_t grid_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/facelet_grid_ctr.sv
// rtl/facelet_grid_ctr.sv - 3x3 grid walker producing registered sample targets
// Targets are kept one bit wider than the raster coordinates so offsets never wrap.
module facelet_grid_ctr
  import facelet_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int CELL_SIZE  = 40,
  parameter int SAMPLE_OFF = 20
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [COORD_W:0] sx,
  input  logic [COORD_W:0] sy,
  output logic [COORD_W:0] tx,
  output logic [COORD_W:0] ty,
  output facelet_idx_t     idx,
  output logic             done
);

  localparam int AW = COORD_W + 1;
  localparam logic [AW-1:0] CELL = AW'(CELL_SIZE);
  localparam logic [AW-1:0] OFF  = AW'(SAMPLE_OFF);
  localparam logic [1:0]    LAST = 2'(GRID_DIM - 1);

  logic [1:0] row;
  logic [1:0] col;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row <= '0;
      col <= '0;
      tx  <= '0;
      ty  <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
      tx  <= sx + OFF;
      ty  <= sy + OFF;
    end else if (advance) begin
      if (col == LAST) begin
        col <= '0;
        tx  <= sx + OFF;
        ty  <= ty + CELL;
        row <= (row == LAST) ? 2'd0 : row + 2'd1;
      end else begin
        col <= col + 2'd1;
        tx  <= tx + CELL;
      end
    end
  end

  assign idx  = grid_idx(row, col);
  assign done = advance && (row == LAST) && (col == LAST);

endmodule

// File: rtl/facelet_sampler.sv
// rtl/facelet_sampler.sv - samples a 3x3 facelet grid from one raster frame and streams it out
// Optional FACELET_AVG_EN averages 4 horizontally adjacent pixels per facelet.
module facelet_sampler
  import facelet_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int PIX_W      = 10,
  parameter int CELL_SIZE  = 40,
  parameter int SAMPLE_OFF = 20,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ds,
  input  logic [COORD_W-1:0] X_Cont,
  input  logic [COORD_W-1:0] Y_Cont,
  input  logic [PIX_W-1:0]   pixelValue,
  input  logic               start,
  input  logic [COORD_W-1:0] CubeX_Start,
  input  logic [COORD_W-1:0] CubeY_Start,
  input  logic               CubeDetected,
  output logic               busy,
  output logic               err,
  output logic               fc_valid,
  input  logic               fc_ready,
  output facelet_idx_t       fc_idx,
  output logic [PIX_W-1:0]   fc_data,
  output logic               fc_last
);

  localparam int AW = COORD_W + 1;
`ifdef FACELET_AVG_EN
  localparam logic [AW-1:0] SPAN_X = AW'(2 * CELL_SIZE + SAMPLE_OFF + 3);
`else
  localparam logic [AW-1:0] SPAN_X = AW'(2 * CELL_SIZE + SAMPLE_OFF);
`endif
  localparam logic [AW-1:0] SPAN_Y   = AW'(2 * CELL_SIZE + SAMPLE_OFF);
  localparam logic [AW-1:0] FW       = AW'(FRAME_W);
  localparam logic [AW-1:0] FH       = AW'(FRAME_H);
  localparam facelet_idx_t  LAST_IDX = facelet_idx_t'(NUM_FACELETS - 1);

  sampler_state_t   state;
  logic [AW-1:0]    sx, sy;
  logic [AW-1:0]    tx, ty;
  logic [AW-1:0]    xe, ye, cube_x, cube_y;
  facelet_idx_t     cap_idx;
  facelet_idx_t     nxt_idx;
  logic             cap;
  logic             cap_done;
  logic [PIX_W-1:0] cap_data;
  logic             frame_start;
  logic             bounds_ok;
  logic             grid_clear;
  logic [PIX_W-1:0] pixbuf [NUM_FACELETS];

  assign xe          = {1'b0, X_Cont};
  assign ye          = {1'b0, Y_Cont};
  assign cube_x      = {1'b0, CubeX_Start};
  assign cube_y      = {1'b0, CubeY_Start};
  assign frame_start = ds && (X_Cont == '0) && (Y_Cont == '0);
  assign bounds_ok   = ((cube_x + SPAN_X) < FW) && ((cube_y + SPAN_Y) < FH);
  assign grid_clear  = (state == SYNC) && frame_start;
  assign nxt_idx     = fc_idx + 4'd1;
  assign busy        = (state != IDLE);

  facelet_grid_ctr #(
    .COORD_W   (COORD_W),
    .CELL_SIZE (CELL_SIZE),
    .SAMPLE_OFF(SAMPLE_OFF)
  ) u_grid (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (grid_clear),
    .advance(cap),
    .sx     (sx),
    .sy     (sy),
    .tx     (tx),
    .ty     (ty),
    .idx    (cap_idx),
    .done   (cap_done)
  );

`ifdef FACELET_AVG_EN
  logic [1:0]       avg_cnt;
  logic [PIX_W+1:0] acc;
  logic [PIX_W+1:0] acc_sum;
  logic             pix_hit;

  // The n-th averaged pixel of a facelet sits n columns right of the target.
  assign pix_hit  = (state == SAMPLE) && ds && (ye == ty) && (xe == tx + AW'(avg_cnt));
  assign cap      = pix_hit && (avg_cnt == 2'd3);
  assign acc_sum  = acc + {2'b00, pixelValue};
  assign cap_data = acc_sum[PIX_W+1:2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      avg_cnt <= '0;
      acc     <= '0;
    end else if (state != SAMPLE || cap) begin
      avg_cnt <= '0;
      acc     <= '0;
    end else if (pix_hit) begin
      avg_cnt <= avg_cnt + 2'd1;
      acc     <= acc_sum;
    end
  end
`else
  assign cap      = (state == SAMPLE) && ds && (xe == tx) && (ye == ty);
  assign cap_data = pixelValue;
`endif

  // Buffer content is only meaningful after a full face, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (cap) pixbuf[cap_idx] <= cap_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      err      <= 1'b0;
      fc_valid <= 1'b0;
      fc_idx   <= '0;
      fc_data  <= '0;
      fc_last  <= 1'b0;
      sx       <= '0;
      sy       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err   <= 1'b0;
            state <= ARM;
          end
        end
        ARM: begin
          if (CubeDetected && bounds_ok) begin
            sx    <= cube_x;
            sy    <= cube_y;
            state <= SYNC;
          end
        end
        SYNC: begin
          if (frame_start) state <= SAMPLE;
        end
        SAMPLE: begin
          if (cap_done) begin
            fc_valid <= 1'b1;
            fc_idx   <= '0;
            fc_data  <= pixbuf[0];
            fc_last  <= 1'b0;
            state    <= OUT;
          end else if (frame_start) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        OUT: begin
          if (fc_ready) begin
            if (fc_idx == LAST_IDX) begin
              fc_valid <= 1'b0;
              fc_last  <= 1'b0;
              fc_idx   <= '0;
              fc_data  <= '0;
              state    <= IDLE;
            end else begin
              fc_idx  <= nxt_idx;
              fc_data <= pixbuf[nxt_idx];
              fc_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
